fdiv_arbiter: RTL and testbench
===============================

# fdiv_arbiter

Round-robin scheduler that shares one multi-cycle floating-point `divider` among `NUM_REQ` requesters (e.g. parallel sigmoid/activation lanes). Accepts divide requests over valid/ready, issues one at a time to the divider, tags the result with the requester ID and returns it on a shared response channel with backpressure. A watchdog cancels a divide that never completes, so a lane cannot hang.

## Interface
- `exp_width`, 8, exponent width.
- `mant_width`, 24, mantissa width incl. hidden bit; `W = exp_width + mant_width`.
- `NUM_REQ`, 4, number of requesters (≥2).
- `TIMEOUT`, 64, maximum WAIT cycles before cancel (≥2).
- `ID_W`, `$clog2(NUM_REQ)`, width of the ID (derived).

Ports:
- `clk`  in  1  clock; the only clock.
- `rst_l`  in  1  reset; asynchronous, active-low.
- `round_mode`  in  3  rounding mode, sampled at grant.
- `req_valid`  in  NUM_REQ  per-requester request valid.
- `req_ready`  out  NUM_REQ  one-hot grant/accept.
- `req_a`  in  NUM_REQ*W  dividends; lane i at `[i*W +: W]`.
- `req_b`  in  NUM_REQ*W  divisors, same packing.
- `resp_valid`  out  1  response valid.
- `resp_ready`  in  1  response accept.
- `resp_id`  out  ID_W  requester ID of the response.
- `resp_data`  out  W  quotient.
- `resp_exceptions`  out  5  flags {invalid, infinite, overflow, underflow, inexact}.
- `div_in_valid`, `div_a`, `div_b`, `div_round_mode`, `div_cancel`  out  1/W/W/3/1  drive the divider.
- `div_in_ready`, `div_out_valid`, `div_out`, `div_exceptions`  in  1/1/W/5  divider returns.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any `req_valid`, grant the first set bit searching upward from `last_grant+1` (mod NUM_REQ). Assert `req_ready[g]` combinationally in this cycle only. Latch `a`, `b`, `round_mode` and `g`, then go to ISSUE.
- ISSUE: `div_in_valid=1` with the latched operands. When `div_in_ready` is high, go to WAIT and clear the watchdog counter.
- WAIT: the counter increments each cycle.
  - On `div_out_valid`, capture `div_out` and `div_exceptions`, then go to RESP.
  - Otherwise, when the counter reaches `TIMEOUT-1`, pulse `div_cancel` for one cycle. Load the canonical quiet NaN (sign 0, exponent all ones, mantissa MSB 1, rest 0; 0x7FC00000 at defaults) with exceptions 5'b10000, then go to RESP.
  - If `div_out_valid` arrives in the same cycle as the timeout, `div_out_valid` wins and no cancel is issued.
- RESP: `resp_valid=1`, and `resp_id`, `resp_data`, `resp_exceptions` are held stable. On `resp_ready`, set `last_grant <= g` and go to IDLE.
- `div_out_valid` seen outside WAIT (stale, post-cancel) is ignored.
- `req_ready` is 0 in every state except IDLE, so only one transaction is in flight.
- Requesters must hold `req_valid` and operands until `req_ready`. Deasserting before grant simply withdraws the request.

## Timing
- Reset (asynchronous) values:
  - State IDLE; `last_grant = NUM_REQ-1`, so lane 0 has top priority first.
  - All outputs 0: `req_ready`, `resp_valid`, `resp_id`, `resp_data`, `resp_exceptions`, `div_in_valid`, `div_a`, `div_b`, `div_round_mode`, `div_cancel`.
- Reset mid-transaction drops the transaction without response and without cancel.
- Cycle 0: grant (`req_ready`).
- Cycle 1: `div_in_valid`.
- Divider acceptance: cycle 1 + k, where k is the number of ISSUE cycles with `div_in_ready` low.
- `resp_valid` rises the cycle after `div_out_valid`.
- Minimum occupancy: 3 cycles + divider latency + resp stall.
- Back-to-back throughput: the next grant comes no earlier than the cycle after the `resp_valid && resp_ready` handshake.
- Fairness: a continuously requesting lane is served within NUM_REQ transactions.

## Structure
- Shared package `fdiv_arb_pkg`:
  - state enum.
  - exception bit index constants.
  - canonical-qNaN function parameterized by `exp_width`/`mant_width`.
  - timeout flag constant 5'b10000.
- Sub-module `rr_grant`: combinational round-robin picker (`req`, `last_grant` → one-hot grant plus index).
- The `divider` is instantiated by the parent next to this block, not inside it.

## Test plan
- Single request on lane 2, a=0x40400000 (3.0), b=0x40000000 (2.0), round_mode 0 → one `resp_valid` with id 2, data 0x3FC00000, exceptions 0.
- All four lanes valid right after reset, each a=0x3F800000 and b = lane+1 → grants in order 0,1,2,3. Data 0x3F800000, 0x3F000000, 0x3EAAAAAB, 0x3E800000; lane 2 has the inexact flag set.
- `resp_ready` held low 10 cycles in RESP → `resp_*` stable, no `req_ready`, no `div_in_valid`. Release → IDLE and the next grant one cycle later.
- 1.0/0.0 → data 0x7F800000, exceptions 5'b01000.
- Stub divider never asserts `div_out_valid`, TIMEOUT=16 → `div_cancel` one cycle at the 16th WAIT cycle. Response 0x7FC00000 / 5'b10000; a late `div_out_valid` is ignored.
- `rst_l` pulsed low during WAIT on lane 3 → all outputs 0 immediately and no response for lane 3. Lanes 1 and 3 requesting afterwards → lane 1 is granted first.

Source files
------------

// File: rtl/fdiv_arb_pkg.sv
// Shared types and constants for the round-robin floating-point divider arbiter.
package fdiv_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    localparam int EXC_INVALID   = 4;
    localparam int EXC_INFINITE  = 3;
    localparam int EXC_OVERFLOW  = 2;
    localparam int EXC_UNDERFLOW = 1;
    localparam int EXC_INEXACT   = 0;

    localparam logic [4:0] TIMEOUT_FLAGS = 5'b10000;

    localparam int QNAN_MAX_W = 128;

    // Sign 0, exponent all ones, top stored mantissa bit set; mant_width counts the hidden bit.
    function automatic logic [QNAN_MAX_W-1:0] canonical_qnan(input int exp_width, input int mant_width);
        logic [QNAN_MAX_W-1:0] v;
        v = '0;
        for (int i = 0; i < QNAN_MAX_W; i++) begin
            if ((i >= mant_width - 1 && i < exp_width + mant_width - 1) || i == mant_width - 2)
                v[i] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/fdiv_arbiter_rr_grant.sv
// Combinational round-robin picker: first requesting lane above last_grant, wrapping around.
module rr_grant #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx,
    output logic               any
);

    logic [ID_W-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        idx       = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            idx = ID_W'((int'(last_grant) + off) % NUM_REQ);
            if (!any && req[idx]) begin
                any       = 1'b1;
                grant[idx] = 1'b1;
                grant_idx = idx;
            end
        end
    end

endmodule

// File: rtl/fdiv_arbiter.sv
// Shares one multi-cycle divider among NUM_REQ lanes, one transaction in flight,
// with a watchdog that cancels a divide that never returns.
module fdiv_arbiter
    import fdiv_arb_pkg::*;
#(
    parameter int exp_width  = 8,
    parameter int mant_width = 24,
    parameter int NUM_REQ    = 4,
    parameter int TIMEOUT    = 64,
    parameter int ID_W       = $clog2(NUM_REQ),
    localparam int W         = exp_width + mant_width
) (
    input  logic                 clk,
    input  logic                 rst_l,
    input  logic [2:0]           round_mode,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ*W-1:0] req_a,
    input  logic [NUM_REQ*W-1:0] req_b,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [ID_W-1:0]      resp_id,
    output logic [W-1:0]         resp_data,
    output logic [4:0]           resp_exceptions,
    output logic                 div_in_valid,
    output logic [W-1:0]         div_a,
    output logic [W-1:0]         div_b,
    output logic [2:0]           div_round_mode,
    output logic                 div_cancel,
    input  logic                 div_in_ready,
    input  logic                 div_out_valid,
    input  logic [W-1:0]         div_out,
    input  logic [4:0]           div_exceptions
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [W-1:0] QNAN = W'(canonical_qnan(exp_width, mant_width));

    arb_state_t state, next_state;

    logic [ID_W-1:0]    last_grant;
    logic [ID_W-1:0]    cur_id;
    logic [ID_W-1:0]    pick_idx;
    logic [NUM_REQ-1:0] pick_grant;
    logic               pick_any;
    logic [W-1:0]       op_a, op_b, res_data;
    logic [2:0]         op_rm;
    logic [4:0]         res_exc;
    logic [CNT_W-1:0]   wd_cnt;
    logic               timeout_hit;

    rr_grant #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_grant (
        .req        (req_valid),
        .last_grant (last_grant),
        .grant      (pick_grant),
        .grant_idx  (pick_idx),
        .any        (pick_any)
    );

    assign timeout_hit = (wd_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l)
            state <= IDLE;
        else
            state <= next_state;
    end

    // req_ready is gated by rst_l so every output reads zero while reset is held.
    always_comb begin
        next_state   = state;
        req_ready    = '0;
        div_in_valid = 1'b0;
        div_cancel   = 1'b0;
        resp_valid   = 1'b0;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    req_ready  = rst_l ? pick_grant : '0;
                    next_state = ISSUE;
                end
            end
            ISSUE: begin
                div_in_valid = 1'b1;
                if (div_in_ready)
                    next_state = WAIT;
            end
            WAIT: begin
                if (div_out_valid) begin
                    next_state = RESP;
                end else if (timeout_hit) begin
                    div_cancel = 1'b1;
                    next_state = RESP;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready)
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Operand latch, watchdog and result capture; a real result beats a same-cycle timeout.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            last_grant <= ID_W'(NUM_REQ - 1);
            cur_id     <= '0;
            op_a       <= '0;
            op_b       <= '0;
            op_rm      <= '0;
            res_data   <= '0;
            res_exc    <= '0;
            wd_cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        op_a   <= req_a[pick_idx*W +: W];
                        op_b   <= req_b[pick_idx*W +: W];
                        op_rm  <= round_mode;
                        cur_id <= pick_idx;
                    end
                end
                ISSUE: begin
                    if (div_in_ready)
                        wd_cnt <= '0;
                end
                WAIT: begin
                    wd_cnt <= wd_cnt + CNT_W'(1);
                    if (div_out_valid) begin
                        res_data <= div_out;
                        res_exc  <= div_exceptions;
                    end else if (timeout_hit) begin
                        res_data <= QNAN;
                        res_exc  <= TIMEOUT_FLAGS;
                    end
                end
                RESP: begin
                    if (resp_ready)
                        last_grant <= cur_id;
                end
                default: ;
            endcase
        end
    end

    assign div_a           = op_a;
    assign div_b           = op_b;
    assign div_round_mode  = op_rm;
    assign resp_id         = cur_id;
    assign resp_data       = res_data;
    assign resp_exceptions = res_exc;

endmodule

// File: tb/tb_fdiv_arbiter.sv
// Self-checking bench for fdiv_arbiter: the bench plays requesters and divider, and predicts grants round-robin.
module tb_fdiv_arbiter;

    localparam int EW = 8;
    localparam int MW = 24;
    localparam int W  = EW + MW;
    localparam int N  = 4;
    localparam int TO = 16;
    localparam int IW = 2;
    localparam logic [W-1:0] QNAN_EXP = 32'h7FC00000;

    logic           clk = 1'b0;
    logic           rst_l;
    logic [2:0]     round_mode;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a, req_b;
    logic           resp_valid, resp_ready;
    logic [IW-1:0]  resp_id;
    logic [W-1:0]   resp_data;
    logic [4:0]     resp_exceptions;
    logic           div_in_valid, div_cancel, div_in_ready, div_out_valid;
    logic [W-1:0]   div_a, div_b, div_out;
    logic [2:0]     div_round_mode;
    logic [4:0]     div_exceptions;

    logic [W-1:0] lane_a [N];
    logic [W-1:0] lane_b [N];
    bit           pending [N];
    int           model_last;
    int           check_count = 0;
    int           pass_count  = 0;
    int           fail_count  = 0;

    fdiv_arbiter #(
        .exp_width  (EW),
        .mant_width (MW),
        .NUM_REQ    (N),
        .TIMEOUT    (TO)
    ) dut (
        .clk             (clk),
        .rst_l           (rst_l),
        .round_mode      (round_mode),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_a           (req_a),
        .req_b           (req_b),
        .resp_valid      (resp_valid),
        .resp_ready      (resp_ready),
        .resp_id         (resp_id),
        .resp_data       (resp_data),
        .resp_exceptions (resp_exceptions),
        .div_in_valid    (div_in_valid),
        .div_a           (div_a),
        .div_b           (div_b),
        .div_round_mode  (div_round_mode),
        .div_cancel      (div_cancel),
        .div_in_ready    (div_in_ready),
        .div_out_valid   (div_out_valid),
        .div_out         (div_out),
        .div_exceptions  (div_exceptions)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        check_count++;
        assert (obs === expv) pass_count++;
        else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, ".req_ready"}, req_ready, 0);
        check_output({tag, ".resp_valid"}, resp_valid, 0);
        check_output({tag, ".resp_id"}, resp_id, 0);
        check_output({tag, ".resp_data"}, resp_data, 0);
        check_output({tag, ".resp_exceptions"}, resp_exceptions, 0);
        check_output({tag, ".div_in_valid"}, div_in_valid, 0);
        check_output({tag, ".div_a"}, div_a, 0);
        check_output({tag, ".div_b"}, div_b, 0);
        check_output({tag, ".div_round_mode"}, div_round_mode, 0);
        check_output({tag, ".div_cancel"}, div_cancel, 0);
    endtask

    task automatic set_request(input int lane, input logic [W-1:0] a, input logic [W-1:0] b);
        lane_a[lane] = a;
        lane_b[lane] = b;
        req_a[lane*W +: W] = a;
        req_b[lane*W +: W] = b;
        req_valid[lane] = 1'b1;
        pending[lane] = 1'b1;
    endtask

    task automatic apply_reset();
        rst_l = 1'b0;
        req_valid = '0;
        for (int l = 0; l < N; l++) pending[l] = 1'b0;
        div_in_ready = 1'b0;
        div_out_valid = 1'b0;
        resp_ready = 1'b0;
        #1;
        check_all_zero("reset");
        repeat (2) tick();
        rst_l = 1'b1;
        model_last = N - 1;
        tick();
    endtask

    function automatic bit any_pending();
        for (int l = 0; l < N; l++) if (pending[l]) return 1'b1;
        return 1'b0;
    endfunction

    // Reference arbitration: first pending lane after the last served one, wrapping.
    function automatic int model_pick();
        for (int off = 1; off <= N; off++)
            if (pending[(model_last + off) % N]) return (model_last + off) % N;
        return 0;
    endfunction

    // One full transaction starting in IDLE with requests already presented; the bench acts as divider.
    task automatic serve(input int stall, input int lat, input int rstall,
                         input logic [W-1:0] q, input logic [4:0] qx, input bit hang);
        int lane;
        logic [2:0] rm;
        logic [N-1:0] g;
        logic [W-1:0] exp_d;
        logic [4:0] exp_x;
        lane = model_pick();
        g = '0;
        g[lane] = 1'b1;
        rm = 3'($urandom_range(0, 4));
        round_mode = rm;
        #1;
        check_output("grant", req_ready, g);
        check_output("resp_valid_idle", resp_valid, 0);
        tick();
        req_valid[lane] = 1'b0;
        pending[lane] = 1'b0;
        round_mode = ~rm;
        check_output("div_in_valid", div_in_valid, 1);
        check_output("div_a", div_a, lane_a[lane]);
        check_output("div_b", div_b, lane_b[lane]);
        check_output("div_round_mode", div_round_mode, rm);
        check_output("req_ready_issue", req_ready, 0);
        div_in_ready = 1'b0;
        for (int i = 0; i < stall; i++) begin
            tick();
            check_output("issue_hold", div_in_valid, 1);
        end
        div_in_ready = 1'b1;
        tick();
        div_in_ready = 1'b0;
        check_output("wait_no_in_valid", div_in_valid, 0);
        if (hang) begin
            for (int c = 1; c <= TO; c++) begin
                check_output("div_cancel", div_cancel, (c == TO));
                tick();
            end
            exp_d = QNAN_EXP;
            exp_x = 5'b10000;
        end else begin
            for (int c = 1; c <= lat; c++) begin
                check_output("no_cancel", div_cancel, 0);
                tick();
            end
            div_out_valid = 1'b1;
            div_out = q;
            div_exceptions = qx;
            #1;
            check_output("cancel_vs_valid", div_cancel, 0);
            tick();
            div_out_valid = 1'b0;
            div_out = $urandom;
            div_exceptions = 5'($urandom);
            exp_d = q;
            exp_x = qx;
        end
        resp_ready = 1'b0;
        for (int i = 0; i < rstall; i++) begin
            if (i == 0) begin
                div_out_valid = 1'b1;
                div_out = ~exp_d;
                div_exceptions = ~exp_x;
            end
            #1;
            check_output("resp_valid_stall", resp_valid, 1);
            check_output("resp_id_stall", resp_id, lane);
            check_output("resp_data_stall", resp_data, exp_d);
            check_output("resp_exc_stall", resp_exceptions, exp_x);
            check_output("req_ready_resp", req_ready, 0);
            check_output("div_in_valid_resp", div_in_valid, 0);
            tick();
            div_out_valid = 1'b0;
        end
        resp_ready = 1'b1;
        #1;
        check_output("resp_valid", resp_valid, 1);
        check_output("resp_id", resp_id, lane);
        check_output("resp_data", resp_data, exp_d);
        check_output("resp_exceptions", resp_exceptions, exp_x);
        tick();
        resp_ready = 1'b0;
        model_last = lane;
        check_output("resp_valid_after", resp_valid, 0);
    endtask

    initial begin
        rst_l = 1'b0;
        round_mode = '0;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        resp_ready = 1'b0;
        div_in_ready = 1'b0;
        div_out_valid = 1'b0;
        div_out = '0;
        div_exceptions = '0;

        apply_reset();
        check_output("idle_no_grant", req_ready, 0);

        $display("[TB] single request on lane 2");
        set_request(2, 32'h40400000, 32'h40000000);
        serve(1, 3, 1, 32'h3FC00000, 5'b00000, 1'b0);

        $display("[TB] four lanes after reset, with a long response stall");
        apply_reset();
        set_request(0, 32'h3F800000, 32'h3F800000);
        set_request(1, 32'h3F800000, 32'h40000000);
        set_request(2, 32'h3F800000, 32'h40400000);
        set_request(3, 32'h3F800000, 32'h40800000);
        serve(0, 2, 0, 32'h3F800000, 5'b00000, 1'b0);
        serve(2, 5, 10, 32'h3F000000, 5'b00000, 1'b0);
        serve(0, 1, 1, 32'h3EAAAAAB, 5'b00001, 1'b0);
        serve(1, 0, 0, 32'h3E800000, 5'b00000, 1'b0);

        $display("[TB] divide by zero, timeout, and result arriving on the timeout cycle");
        set_request(1, 32'h3F800000, 32'h00000000);
        serve(0, 4, 1, 32'h7F800000, 5'b01000, 1'b0);
        set_request(0, 32'h3F800000, 32'h40400000);
        serve(0, 0, 3, 32'hDEADBEEF, 5'b00000, 1'b1);
        set_request(2, 32'h40A00000, 32'h40000000);
        serve(1, TO - 1, 2, 32'h40200000, 5'b00000, 1'b0);

        $display("[TB] randomized traffic");
        for (int t = 0; t < 16; t++) begin
            for (int l = 0; l < N; l++)
                if (!pending[l] && $urandom_range(0, 1) == 1) set_request(l, $urandom, $urandom);
            if (!any_pending()) set_request($urandom_range(0, N - 1), $urandom, $urandom);
            serve($urandom_range(0, 3),
                  ($urandom_range(0, 5) == 0) ? TO - 1 : $urandom_range(0, 6),
                  $urandom_range(0, 3), $urandom, 5'($urandom),
                  ($urandom_range(0, 5) == 0));
        end

        $display("[TB] reset during WAIT on lane 3");
        apply_reset();
        set_request(3, $urandom, $urandom);
        #1;
        check_output("grant_lane3", req_ready, 4'b1000);
        tick();
        req_valid[3] = 1'b0;
        pending[3] = 1'b0;
        div_in_ready = 1'b1;
        tick();
        div_in_ready = 1'b0;
        tick();
        tick();
        check_output("wait_no_resp", resp_valid, 0);
        rst_l = 1'b0;
        set_request(1, $urandom, $urandom);
        set_request(3, $urandom, $urandom);
        #1;
        check_all_zero("mid_reset");
        tick();
        tick();
        rst_l = 1'b1;
        model_last = N - 1;
        serve(0, 2, 1, $urandom, 5'($urandom), 1'b0);
        serve(1, 1, 0, $urandom, 5'($urandom), 1'b0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
